// File: rtl/lp_gearbox_pkg.sv
// Shared types and helpers for the low-rate 4-to-6 gearbox and its phase sequencer.
package lp_gearbox_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_CHECK,
    ST_LOCKED
  } lp_phase_state_t;

  localparam int unsigned LP_PERIOD = 3;

  // Gearbox ce duty pattern for the 3-cycle ratio: active in phases 0 and 2.
  function automatic logic lp_ce_pattern(input int unsigned phase_cnt);
    return (phase_cnt == 0) || (phase_cnt == 2);
  endfunction

endpackage

// File: rtl/lp_ce_monitor.sv
// Watches the gearbox ce output against its expected duty pattern once a lock
// episode has settled, and keeps a sticky error flag.
module lp_ce_monitor
  import lp_gearbox_pkg::*;
#(
  parameter int unsigned PERIOD = LP_PERIOD,
  parameter int unsigned PW     = $clog2(PERIOD)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          locked_i,
  input  logic          phase_i,
  input  logic [PW-1:0] phase_cnt_i,
  input  logic          ce_i,
  input  logic          clear_i,
  output logic          ce_err_o
);

  localparam int unsigned AW       = $clog2(PERIOD + 2);
  localparam logic [AW-1:0] ARM_DONE = AW'(PERIOD + 1);
  localparam bit          MON_EN   = (PERIOD == 3);

  logic [AW-1:0] arm_q, arm_d;
  logic          ce_err_q, ce_err_d;
  logic          armed, mismatch;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      arm_q    <= '0;
      ce_err_q <= 1'b0;
    end else begin
      arm_q    <= arm_d;
      ce_err_q <= ce_err_d;
    end
  end

  // Arming counter starts on the first phase pulse of a lock episode and
  // saturates PERIOD+1 cycles later; leaving LOCKED disarms it.
  always_comb begin
    arm_d = arm_q;
    if (!locked_i) begin
      arm_d = '0;
    end else if (arm_q == '0) begin
      arm_d = phase_i ? AW'(1) : '0;
    end else if (arm_q != ARM_DONE) begin
      arm_d = arm_q + 1'b1;
    end
  end

  always_comb begin
    armed    = (arm_q == ARM_DONE);
    mismatch = MON_EN && locked_i && armed &&
               (ce_i != lp_ce_pattern(32'(phase_cnt_i)));
    ce_err_d = ce_err_q;
    if (clear_i) begin
      ce_err_d = 1'b0;
    end else if (mismatch) begin
      ce_err_d = 1'b1;
    end
  end

  assign ce_err_o = ce_err_q;

endmodule

// File: rtl/lp_phase_ctrl.sv
// Phase sequencer: locks a modulo-PERIOD counter to the slow-clock sync strobe,
// drives the gearbox phase pulse while locked and counts sync faults.
module lp_phase_ctrl
  import lp_gearbox_pkg::*;
#(
  parameter int unsigned PERIOD     = LP_PERIOD,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 2,
  parameter int unsigned ERRW       = 16
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            enable_i,
  input  logic            resync_i,
  input  logic            sync_i,
  input  logic            ce_i,
  output logic            phase_o,
  output logic            locked_o,
  output logic [ERRW-1:0] err_cnt_o,
  output logic            ce_err_o
);

  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MW = $clog2(MISS_LIMIT + 1);

  localparam logic [PW-1:0] CNT_LAST  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] CNT_ONE   = PW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  lp_phase_state_t state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [GW-1:0]   good_q, good_d;
  logic [MW-1:0]   miss_q, miss_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            phase_q, phase_d;
  logic            slot, good_sync, bad_sync, missing, clear_all;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      good_q  <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      phase_q <= phase_d;
    end
  end

  // Disable beats resync, and resync beats any sync seen in the same cycle.
  // Once locked the counter flywheels; only CHECK and ACQUIRE re-anchor it.
  always_comb begin
    cnt_inc   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    slot      = (cnt_q == '0);
    good_sync = sync_i && slot;
    bad_sync  = sync_i && !slot;
    missing   = slot && !sync_i;
    clear_all = enable_i && resync_i;

    state_d = state_q;
    cnt_d   = cnt_inc;
    good_d  = good_q;
    miss_d  = miss_q;
    err_d   = err_q;

    if (!enable_i) begin
      state_d = ST_IDLE;
      good_d  = '0;
      miss_d  = '0;
    end else if (resync_i) begin
      state_d = ST_ACQUIRE;
      good_d  = '0;
      miss_d  = '0;
      err_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (sync_i) begin
            cnt_d   = CNT_ONE;
            good_d  = '0;
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (good_sync) begin
            if (good_q == GOOD_LAST) begin
              good_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else if (bad_sync) begin
            cnt_d  = CNT_ONE;
            good_d = '0;
          end else if (missing) begin
            good_d  = '0;
            state_d = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          if (good_sync) begin
            miss_d = '0;
          end else if (bad_sync || missing) begin
            err_d = (err_q == '1) ? err_q : err_q + 1'b1;
            if (miss_q == MISS_LAST) begin
              miss_d  = '0;
              state_d = ST_ACQUIRE;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    locked_o = (state_q == ST_LOCKED);
    phase_d  = (state_d == ST_LOCKED) && (cnt_d == '0);
  end

  assign phase_o   = phase_q;
  assign err_cnt_o = err_q;

  lp_ce_monitor #(
    .PERIOD (PERIOD),
    .PW     (PW)
  ) u_ce_monitor (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .locked_i    (locked_o),
    .phase_i     (phase_q),
    .phase_cnt_i (cnt_q),
    .ce_i        (ce_i),
    .clear_i     (clear_all),
    .ce_err_o    (ce_err_o)
  );

endmodule

// File: tb/tb_lp_phase_ctrl.sv
// Bench for lp_phase_ctrl: directed lock/flywheel/re-anchor/ce/priority/saturation
// sequences followed by random traffic, all compared against an anchor-based model.
module tb_lp_phase_ctrl;

  localparam int P     = 3;
  localparam int LOCK  = 4;
  localparam int MISSL = 2;

  localparam int M_IDLE   = 0;
  localparam int M_ACQ    = 1;
  localparam int M_CHECK  = 2;
  localparam int M_LOCKED = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        enable = 1'b0, resync = 1'b0, sync = 1'b0, ceIn = 1'b0;
  logic        phase16, locked16, ceErr16;
  logic [15:0] err16;
  logic        phase4, locked4, ceErr4;
  logic [3:0]  err4;

  int checks = 0;
  int errors = 0;
  bit cmpOn  = 0;

  int mMode, mCyc, mAnchor, mGood, mMiss, mErr, mFirst;
  bit mCeErr;

  always #5 clk = ~clk;

  lp_phase_ctrl #(.PERIOD(P), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISSL), .ERRW(16)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .resync_i(resync), .sync_i(sync),
    .ce_i(ceIn), .phase_o(phase16), .locked_o(locked16), .err_cnt_o(err16), .ce_err_o(ceErr16)
  );

  lp_phase_ctrl #(.PERIOD(P), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISSL), .ERRW(4)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .resync_i(resync), .sync_i(sync),
    .ce_i(ceIn), .phase_o(phase4), .locked_o(locked4), .err_cnt_o(err4), .ce_err_o(ceErr4)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d cycle=%0d time=%0t",
               name, actual, expected, mCyc, $time);
    end
  endtask

  function automatic bit slotAt(input int t, input int a);
    return (t >= a) && ((t - a) % P == 0);
  endfunction

  function automatic bit gearCe(input int t, input int a);
    int k;
    k = (t - a) % P;
    return (t >= a) && (k == 0 || k == 2);
  endfunction

  task automatic modelReset();
    mMode = M_IDLE; mCyc = 0; mAnchor = 0; mGood = 0; mMiss = 0;
    mErr = 0; mFirst = -1; mCeErr = 0;
  endtask

  // Slots are tracked as an anchor cycle plus a multiple of P rather than as a counter.
  task automatic modelStep(input bit en, input bit rs, input bit sy, input bit c);
    bit slot;
    int k;
    k = 0;
    slot = 0;
    if (mMode == M_CHECK || mMode == M_LOCKED) begin
      k = (mCyc - mAnchor) % P;
      slot = (k == 0);
    end
    if (mMode == M_LOCKED) begin
      if (slot && mFirst < 0) mFirst = mCyc;
      if (P == 3 && mFirst >= 0 && mCyc >= mFirst + P + 1 && c != (k == 0 || k == 2))
        mCeErr = 1;
    end
    if (!en) begin
      mMode = M_IDLE; mGood = 0; mMiss = 0;
    end else if (rs) begin
      mMode = M_ACQ; mGood = 0; mMiss = 0; mErr = 0; mCeErr = 0;
    end else begin
      case (mMode)
        M_IDLE: mMode = M_ACQ;
        M_ACQ: if (sy) begin mAnchor = mCyc; mGood = 0; mMode = M_CHECK; end
        M_CHECK: begin
          if (sy && slot) begin
            mGood++;
            if (mGood == LOCK) mMode = M_LOCKED;
          end else if (sy) begin
            mAnchor = mCyc; mGood = 0;
          end else if (slot) begin
            mMode = M_ACQ;
          end
        end
        M_LOCKED: begin
          if (sy && slot) begin
            mMiss = 0;
          end else if (sy || slot) begin
            mMiss++; mErr++;
            if (mMiss >= MISSL) begin mMode = M_ACQ; mMiss = 0; end
          end
        end
        default: ;
      endcase
    end
    if (mMode != M_LOCKED) mFirst = -1;
    mCyc++;
  endtask

  task automatic applyStimulus(input bit en, input bit rs, input bit sy, input bit c);
    enable = en; resync = rs; sync = sy; ceIn = c;
    @(posedge clk);
    modelStep(en, rs, sy, c);
    @(negedge clk);
  endtask

  task automatic doReset();
    cmpOn = 0;
    #1;
    rstn = 1'b0; enable = 1'b1; resync = 1'b0; sync = 1'b0; ceIn = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cmpOn = 1;
  endtask

  initial begin
    bit expPhase;
    forever begin
      @(negedge clk);
      if (cmpOn) begin
        expPhase = (mMode == M_LOCKED) && ((mCyc - mAnchor) % P == 0);
        checkOutput("locked16", locked16, mMode == M_LOCKED);
        checkOutput("phase16", phase16, expPhase);
        checkOutput("err16", err16, (mErr > 65535) ? 65535 : mErr);
        checkOutput("ceErr16", ceErr16, mCeErr);
        checkOutput("locked4", locked4, mMode == M_LOCKED);
        checkOutput("phase4", phase4, expPhase);
        checkOutput("err4", err4, (mErr > 15) ? 15 : mErr);
        checkOutput("ceErr4", ceErr4, mCeErr);
      end
    end
  end

  initial begin
    bit en, rs, sy, c;
    int r, src;

    // Clean lock, single miss flywheel, then two consecutive misses drop lock.
    doReset();
    checkOutput("rstLocked", locked16, 0);
    checkOutput("rstPhase", phase16, 0);
    checkOutput("rstErr", err16, 0);
    checkOutput("rstCeErr", ceErr16, 0);
    for (int t = 0; t < 56; t++) begin
      sy = slotAt(t, 10) && t != 31 && t != 46 && t != 49;
      applyStimulus(1'b1, 1'b0, sy, gearCe(t, 10));
      case (t + 1)
        22: checkOutput("lockPre", locked16, 0);
        23: checkOutput("lockRise", locked16, 1);
        25: checkOutput("phaseFirst", phase16, 1);
        26: checkOutput("phaseGap", phase16, 0);
        28: checkOutput("phaseSecond", phase16, 1);
        32: begin
          checkOutput("flyErr", err16, 1);
          checkOutput("flyLocked", locked16, 1);
        end
        34: checkOutput("flyPhase", phase16, 1);
        45: checkOutput("gearCeClean", ceErr16, 0);
        47: checkOutput("missOneErr", err16, 2);
        50: begin
          checkOutput("missTwoLocked", locked16, 0);
          checkOutput("missTwoErr", err16, 3);
        end
        52: checkOutput("phaseStopped", phase16, 0);
        default: ;
      endcase
    end

    // ce fault, resync priority over a coincident good sync, async reset mid-lock.
    doReset();
    for (int t = 0; t < 70; t++) begin
      c = (t >= 41) ? 1'b0 : gearCe(t, 10);
      applyStimulus(1'b1, t == 46, slotAt(t, 10), c);
      case (t + 1)
        42: checkOutput("ceErrPre", ceErr16, 0);
        43: checkOutput("ceErrSet", ceErr16, 1);
        45: checkOutput("ceErrSticky", ceErr4, 1);
        47: begin
          checkOutput("resyncLocked", locked16, 0);
          checkOutput("resyncCeErr", ceErr16, 0);
        end
        61: checkOutput("relockPre", locked16, 0);
        62: checkOutput("relock", locked16, 1);
        70: begin
          checkOutput("preRstCeErr", ceErr16, 1);
          checkOutput("preRstPhase", phase16, 1);
          checkOutput("preRstLocked", locked4, 1);
        end
        default: ;
      endcase
    end
    cmpOn = 0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("asyncRstLocked", locked16, 0);
    checkOutput("asyncRstPhase", phase16, 0);
    checkOutput("asyncRstCeErr", ceErr16, 0);
    checkOutput("asyncRstPhase4", phase4, 0);

    // Re-anchor in CHECK, then alternate missing/good slots to saturate the 4-bit counter.
    doReset();
    for (int t = 0; t < 150; t++) begin
      sy = (t == 10 || t == 13 || t == 16) ||
           (slotAt(t, 18) && (t < 33 || ((t - 33) / 3) % 2 == 1));
      applyStimulus(1'b1, 1'b0, sy, gearCe(t, (t >= 18) ? 18 : 10));
      case (t + 1)
        30: checkOutput("anchorLockPre", locked16, 0);
        31: checkOutput("anchorLock", locked16, 1);
        32: checkOutput("anchorPhaseGap", phase16, 0);
        33: checkOutput("anchorPhase", phase16, 1);
        150: begin
          checkOutput("satErr4", err4, 15);
          checkOutput("satErr16", err16, 20);
          checkOutput("satLocked", locked4, 1);
        end
        default: ;
      endcase
    end

    // Random traffic around a mostly periodic sync source.
    doReset();
    src = 0;
    for (int t = 0; t < 3000; t++) begin
      r = $urandom_range(0, 999);
      en = 1'b1;
      rs = 1'b0;
      if (r < 8) en = 1'b0;
      else if (r < 16) rs = 1'b1;
      if ($urandom_range(0, 199) == 0) src = $urandom_range(0, 2);
      sy = ((mCyc + P - src) % P == 0);
      if ($urandom_range(0, 19) == 0) sy = ~sy;
      c = gearCe(mCyc + P, src);
      if ($urandom_range(0, 49) == 0) c = ~c;
      applyStimulus(en, rs, sy, c);
    end

    cmpOn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
